eth_tx_packet_arbiter: RTL and testbench

- Packet-granular round-robin arbiter sharing one Ethernet MAC TX AXI-Stream port (xg0 or mgmt0) between NUM_PORTS frame sources, e.g. firmware TX path and hardware-generated frames.
- Never interleaves beats of different frames on the output.
- Discards traffic while the MAC link is down so sources never deadlock.
- Sits in the MAC TX clock domain, directly upstream of the MAC axi_tx port.

---
 rtl/eth_tx_arb_pkg.sv | 6 +
 rtl/eth_rr_picker.sv | 23 ++
 rtl/eth_tx_packet_arbiter.sv | 113 +++++++++++
 tb/tb_eth_tx_packet_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: shared FSM type and port limits for the Ethernet TX packet arbiter
package eth_tx_arb_pkg;
    localparam int MAX_ARB_PORTS = 8;
    localparam int PTR_W = $clog2(MAX_ARB_PORTS);
    typedef enum logic [1:0] {IDLE, FORWARD, FLUSH} arb_state_t;
endpackage

// File: rtl/eth_rr_picker.sv
// eth_rr_picker: combinational round-robin first-set search starting at ptr
module eth_rr_picker
    import eth_tx_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             found
);
    // Scan offsets from farthest to nearest so the nearest requester wins last
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end
    assign found = |req;
endmodule

// File: rtl/eth_tx_packet_arbiter.sv
// eth_tx_packet_arbiter: frame-granular round-robin mux onto one MAC TX AXI-Stream port.
// Define ETH_TX_ARB_STATS_EN to add per-source forwarded-frame counters (tx_frame_count).
module eth_tx_packet_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              aclk,
    input  logic                              areset_n,
    input  logic                              link_up,
    input  logic [NUM_PORTS-1:0]              s_tvalid,
    output logic [NUM_PORTS-1:0]              s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]              s_tlast,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_tkeep,
    output logic                              m_tlast,
    output logic [NUM_PORTS-1:0]              grant,
    output logic [31:0]                       drop_count
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]           tx_frame_count
`endif
);
    localparam int KW = DATA_WIDTH / 8;

    arb_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d, pick;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d, gidx, gnext;
    logic [31:0]          drop_count_q, drop_count_d;
    logic                 found, fwd, beat, last_beat;

    eth_rr_picker #(.N(NUM_PORTS)) u_picker (
        .req   (s_tvalid),
        .ptr   (rr_ptr_q),
        .gnt   (pick),
        .found (found)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (grant_q[i]) gidx = PTR_W'(i);
    end

    assign gnext      = (gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : gidx + PTR_W'(1);
    assign fwd        = state_q == FORWARD;
    assign m_tvalid   = fwd & |(s_tvalid & grant_q);
    assign m_tdata    = fwd ? s_tdata[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_tkeep    = fwd ? s_tkeep[gidx*KW +: KW] : '0;
    assign m_tlast    = fwd & s_tlast[gidx];
    // A flushing source is always ready so it can drain while the link is down
    assign s_tready   = fwd ? (grant_q & {NUM_PORTS{m_tready}}) : (state_q == FLUSH) ? grant_q : '0;
    assign beat       = |(s_tvalid & s_tready);
    assign last_beat  = beat & s_tlast[gidx];
    assign grant      = grant_q;
    assign drop_count = drop_count_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        drop_count_d = drop_count_q;
        if (state_q == IDLE) begin
            if (found) begin
                grant_d = pick;
                state_d = link_up ? FORWARD : FLUSH;
            end
        end else if (last_beat) begin
            grant_d  = '0;
            rr_ptr_d = gnext;
            state_d  = IDLE;
            if (state_q == FLUSH) drop_count_d = drop_count_q + 32'd1;
        end else if (fwd && !link_up) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_count_q <= drop_count_d;
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [NUM_PORTS*32-1:0] tx_frame_count_q, tx_frame_count_d;

    always_comb begin
        tx_frame_count_d = tx_frame_count_q;
        if (fwd && last_beat)
            tx_frame_count_d[gidx*32 +: 32] = tx_frame_count_q[gidx*32 +: 32] + 32'd1;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) tx_frame_count_q <= '0;
        else           tx_frame_count_q <= tx_frame_count_d;
    end

    assign tx_frame_count = tx_frame_count_q;
`endif
endmodule

// File: tb/tb_eth_tx_packet_arbiter.sv
// tb_eth_tx_packet_arbiter: directed scoreboard bench for eth_tx_packet_arbiter
module tb_eth_tx_packet_arbiter;
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [1:0]  g;
    } beat_t;

    logic        aclk = 0, areset_n = 0, link_up = 1;
    logic [1:0]  s_tvalid, s_tready, s_tlast, grant;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        m_tvalid, m_tready = 1, m_tlast;
    logic [31:0] m_tdata, drop_count;
    logic [3:0]  m_tkeep;
`ifdef ETH_TX_ARB_STATS_EN
    logic [63:0] tx_frame_count;
`endif

    logic        vld [2];
    logic [31:0] dat [2];
    logic [3:0]  kp  [2];
    logic        lst [2];
    int          mode = 0, tests = 0, fails = 0, nbeats = 0;
    logic        flush_chk = 0;
    beat_t       sbq[$];
    beat_t       e;

    always #5 aclk = ~aclk;

    eth_tx_packet_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32)) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .link_up    (link_up),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .grant      (grant),
        .drop_count (drop_count)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .tx_frame_count (tx_frame_count)
`endif
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i]         = vld[i];
            s_tdata[i*32 +: 32] = dat[i];
            s_tkeep[i*4 +: 4]   = kp[i];
            s_tlast[i]          = lst[i];
        end
    end

    function automatic logic [31:0] mk(input int p, input int f, input int k);
        logic [31:0] pv, fv, kv;
        pv = p; fv = f; kv = k;
        return {pv[3:0], fv[11:0], kv[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input int n, input int fid, input int nfwd);
        beat_t b;
        for (int k = 0; k < nfwd; k++) begin
            b.d = mk(p, fid, k);
            b.k = (k == n - 1) ? 4'h3 : 4'hF;
            b.l = (k == n - 1);
            b.g = (p == 0) ? 2'b01 : 2'b10;
            sbq.push_back(b);
        end
    endtask

    // Presents one frame on source p; link_up is dropped while beat index drop is offered
    task automatic send(input int p, input int n, input int fid, input int drop);
        int w;
        for (int k = 0; k < n; k++) begin
            vld[p] = 1;
            dat[p] = mk(p, fid, k);
            kp[p]  = (k == n - 1) ? 4'h3 : 4'hF;
            lst[p] = (k == n - 1);
            if (k == drop) link_up = 0;
            w = 0;
            @(negedge aclk);
            while (!s_tready[p] && w < 100) begin
                @(negedge aclk);
                w++;
            end
            if (w >= 100) begin
                tests++;
                fails++;
                $display("FAIL timeout src%0d frame %0d beat %0d: ready never seen", p, fid, k);
                vld[p] = 0;
                return;
            end
            @(posedge aclk);
            #1;
        end
        vld[p] = 0;
    endtask

    initial forever begin
        @(posedge aclk);
        #1;
        m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~m_tready : 1'b0;
    end

    always @(negedge aclk) begin
        if (areset_n) begin
            if (flush_chk && grant == 2'b10) chk("flush_sready1", {62'd0, s_tready}, 2);
            if (m_tvalid) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h expected no output", m_tdata);
                end else begin
                    chk("grant_owner", {62'd0, grant}, {62'd0, sbq[0].g});
                    chk("sready_mirror", {62'd0, s_tready}, m_tready ? {62'd0, sbq[0].g} : 64'd0);
                    if (m_tready) begin
                        e = sbq.pop_front();
                        chk("tdata", {32'd0, m_tdata}, {32'd0, e.d});
                        chk("tkeep", {60'd0, m_tkeep}, {60'd0, e.k});
                        chk("tlast", {63'd0, m_tlast}, {63'd0, e.l});
                        nbeats++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, w;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 0; dat[i] = 0; kp[i] = 0; lst[i] = 0;
        end
        repeat (3) @(negedge aclk);
        chk("rst_grant", {62'd0, grant}, 0);
        chk("rst_mvalid", {63'd0, m_tvalid}, 0);
        chk("rst_sready", {62'd0, s_tready}, 0);
        chk("rst_drop", {32'd0, drop_count}, 0);
        areset_n = 1;
        @(posedge aclk);
        #1;

        // Round-robin: both sources continuously valid
        for (int f = 0; f < 3; f++) begin
            push(0, 2, f, 2);
            push(1, 2, f, 2);
        end
        fork
            for (int f = 0; f < 3; f++) send(0, 2, f, -1);
            for (int f = 0; f < 3; f++) send(1, 2, f, -1);
        join
        chk("rr_sb_empty", sbq.size(), 0);

        // Single 4-beat frame with IDLE bubble
        push(0, 4, 5, 4);
        fork
            send(0, 4, 5, -1);
            begin
                @(negedge aclk);
                chk("bubble_mvalid", {63'd0, m_tvalid}, 0);
                chk("bubble_grant", {62'd0, grant}, 0);
            end
        join
        chk("single_idle_grant", {62'd0, grant}, 0);
        chk("single_sb_empty", sbq.size(), 0);

        // Output backpressure on a 5-beat frame
        mode = 1;
        b0 = nbeats;
        push(0, 5, 10, 5);
        send(0, 5, 10, -1);
        mode = 0;
        chk("bp_beats", nbeats - b0, 5);
        chk("bp_sb_empty", sbq.size(), 0);

        // Link down: three frames from source 1 discarded
        link_up = 0;
        flush_chk = 1;
        for (int f = 0; f < 3; f++) send(1, 2, 30 + f, -1);
        flush_chk = 0;
        chk("flush_drop", {32'd0, drop_count}, 3);
        chk("flush_grant", {62'd0, grant}, 0);

        // Link falls while beat 2 of a 6-beat frame is transferred
        link_up = 1;
        push(0, 6, 20, 2);
        send(0, 6, 20, 1);
        link_up = 1;
        chk("linkfall_drop", {32'd0, drop_count}, 4);
        chk("linkfall_sb_empty", sbq.size(), 0);
        push(1, 2, 21, 2);
        send(1, 2, 21, -1);
        chk("recover_sb_empty", sbq.size(), 0);
        chk("recover_drop", {32'd0, drop_count}, 4);
`ifdef ETH_TX_ARB_STATS_EN
        chk("stats_src0", {32'd0, tx_frame_count[31:0]}, 5);
        chk("stats_src1", {32'd0, tx_frame_count[63:32]}, 4);
`endif

        // Reset asserted mid-FORWARD
        mode = 2;
        repeat (2) @(posedge aclk);
        #1;
        push(0, 4, 99, 1);
        vld[0] = 1; dat[0] = mk(0, 99, 0); kp[0] = 4'hF; lst[0] = 0;
        w = 0;
        @(negedge aclk);
        while (grant != 2'b01 && w < 20) begin
            @(negedge aclk);
            w++;
        end
        chk("midfwd_grant", {62'd0, grant}, 1);
        #2 areset_n = 0;
        #1;
        chk("arst_grant", {62'd0, grant}, 0);
        chk("arst_mvalid", {63'd0, m_tvalid}, 0);
        chk("arst_sready", {62'd0, s_tready}, 0);
        chk("arst_drop", {32'd0, drop_count}, 0);
`ifdef ETH_TX_ARB_STATS_EN
        chk("arst_stats", tx_frame_count, 0);
`endif
        vld[0] = 0;
        sbq.delete();
        @(negedge aclk);
        areset_n = 1;
        repeat (2) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
